// File: rtl/demux_1x8_stream.sv
// Registered 1-to-8 stream demultiplexer with one-entry output register per channel.
// Unicast goes to one channel, broadcast to all eight at once; acc_cnt counts accepted transfers.
module demux_1x8_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [CNT_W-1:0]     acc_cnt
);

    logic [7:0] free;
    logic [7:0] target;
    logic [7:0] load;
    logic       accept;

    // A channel can take new data when it is empty or being drained this cycle,
    // so out_ready reaches in_ready combinationally with no bubble.
    always_comb begin
        free     = ~out_valid | out_ready;
        target   = in_bcast ? 8'hFF : (8'h01 << in_sel);
        in_ready = in_bcast ? (&free) : free[in_sel];
        accept   = in_valid & in_ready;
        load     = accept ? target : 8'h00;
    end

    // Stage p1: per-channel output registers and the accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            acc_cnt   <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (load[k]) begin
                    out_valid[k]                 <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_1x8_stream.sv
// Directed and randomized bench for demux_1x8_stream against a per-channel array model.
module tb_demux_1x8_stream;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [2:0]         in_sel;
    logic               in_bcast;
    logic               in_valid;
    logic               in_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [CNT_W-1:0]   acc_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one entry per channel plus an integer transfer count.
    bit              mv[8];
    logic [WIDTH-1:0] md[8];
    int              mcnt;

    always #5 clk = ~clk;

    demux_1x8_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc_cnt(acc_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        mcnt = 0;
    endtask

    function automatic bit exp_ready(input logic [2:0] s, input logic b, input logic [7:0] r);
        bit all_free = 1'b1;
        for (int k = 0; k < 8; k++)
            if (mv[k] && !r[k]) all_free = 1'b0;
        if (b) return all_free;
        return !mv[s] || r[s];
    endfunction

    task automatic check_state(input string tag);
        logic [7:0]         ev;
        logic [8*WIDTH-1:0] ed;
        for (int k = 0; k < 8; k++) begin
            ev[k] = mv[k];
            ed[k*WIDTH +: WIDTH] = md[k];
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        check({tag, ".out_data"},  64'(out_data),  64'(ed));
        check({tag, ".acc_cnt"},   64'(acc_cnt),   64'(mcnt));
    endtask

    // One cycle: drive at negedge, check in_ready, clock, update model, check state.
    task automatic step(input logic [7:0] d, input logic [2:0] s, input logic b,
                        input logic v, input logic [7:0] r);
        bit er;
        bit acc;
        in_data = d; in_sel = s; in_bcast = b; in_valid = v; out_ready = r;
        #1;
        er = exp_ready(s, b, r);
        check("in_ready", 64'(in_ready), 64'(er));
        @(posedge clk);
        acc = v && er;
        for (int k = 0; k < 8; k++) begin
            if (acc && (b || (s == 3'(k)))) begin
                mv[k] = 1'b1;
                md[k] = d;
            end else if (r[k]) begin
                mv[k] = 1'b0;
            end
        end
        if (acc) mcnt = (mcnt + 1) % (1 << CNT_W);
        #1;
        check_state("step");
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        rst = 1'b0;

        // Unicast to ch3, then ch3 blocked while ch5 accepts.
        step(8'hA5, 3'd3, 1'b0, 1'b1, 8'h00);
        check("uni.valid", 64'(out_valid), 64'h08);
        check("uni.slice3", 64'(out_data[31:24]), 64'hA5);
        check("uni.cnt", 64'(acc_cnt), 64'd1);
        step(8'h11, 3'd3, 1'b0, 1'b1, 8'h00);
        check("uni.held", 64'(in_ready), 64'd0);
        step(8'h5A, 3'd5, 1'b0, 1'b1, 8'h00);
        check("uni.ch5", 64'(out_valid), 64'h28);

        // Back-pressure release: drain and load on ch3 in one edge.
        step(8'h3C, 3'd3, 1'b0, 1'b1, 8'h00);
        step(8'h3C, 3'd3, 1'b0, 1'b1, 8'h08);
        check("bp.valid3", 64'(out_valid[3]), 64'd1);
        check("bp.slice3", 64'(out_data[31:24]), 64'h3C);

        // Broadcast waits for every channel, then loads all eight at once.
        step(8'h66, 3'd6, 1'b0, 1'b1, 8'h00);
        step(8'h77, 3'd2, 1'b1, 1'b1, 8'h00);
        check("bc.blocked", 64'(in_ready), 64'd0);
        step(8'h77, 3'd2, 1'b1, 1'b1, 8'hFF);
        check("bc.valid", 64'(out_valid), 64'hFF);
        check("bc.data", 64'(out_data), 64'h7777_7777_7777_7777);

        // Streaming at full throughput.
        for (int i = 0; i < 8; i++)
            step(8'(8'h10 + i), 3'(i), 1'b0, 1'b1, 8'hFF);
        check("stream.data", 64'(out_data[63:56]), 64'h17);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step(8'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0),
                 1'($urandom), 8'($urandom));

        // Counter wrap: 257 accepts from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 257; i++)
            step(8'($urandom), 3'($urandom), 1'b0, 1'b1, 8'hFF);
        check("wrap.cnt", 64'(acc_cnt), 64'd1);

        // Async reset between edges with ch0 and ch7 holding data.
        step(8'h00, 3'd0, 1'b0, 1'b0, 8'hFF);
        step(8'h11, 3'd0, 1'b0, 1'b1, 8'h00);
        step(8'h22, 3'd7, 1'b0, 1'b1, 8'h00);
        check("ar.pre", 64'(out_valid), 64'h81);
        #2 rst = 1'b1;
        #1;
        check("ar.valid", 64'(out_valid), 64'h00);
        check("ar.cnt", 64'(acc_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(8'hA5, 3'd3, 1'b0, 1'b1, 8'h00);
        check("ar.uni", 64'(out_valid), 64'h08);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/demux_1x8_stream.md
Name: demux_1x8_stream

Overview:
- Registered 1-to-8 stream demultiplexer. It is the inverse of the team's 8:1 selector.
- One input stream is routed to one of eight output channels, or to all eight at once, under valid/ready handshakes.
- Each channel has a one-entry output register, so a stalled sink blocks only transfers addressed to its own channel.
- A wrapping counter tracks accepted transfers for debug.

Parameters:
- WIDTH, 8, data bits per transfer.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  payload.
- in_sel  input  3  destination channel; 000 selects ch0, 001 selects ch1, …, 111 selects ch7 (same order as the 8:1 selector inputs a..h).
- in_bcast  input  1  1 = deliver to all eight channels; in_sel is ignored.
- in_valid  input  1  source has a transfer.
- in_ready  output  1  block can accept the current transfer.
- out_data  output  8*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  8  channel k holds data.
- out_ready  input  8  sink k accepts data.
- acc_cnt  output  CNT_W  number of accepted input transfers, modulo 2^CNT_W.

Behaviour:
- Reset (asserted asynchronously, at any time): out_valid=0, out_data=0, acc_cnt=0. Any pending entries are discarded with no completion. Release is synchronous to clk.
- free[k] = !out_valid[k] | out_ready[k].
- in_ready rules:
  - Unicast: in_ready = free[in_sel].
  - Broadcast: in_ready = AND of free[0..7].
  - in_ready is combinational from in_sel, in_bcast, out_valid and out_ready. It does not depend on in_valid.
  - The path out_ready→in_ready is combinational by design; there is no extra bubble.
- Accept condition: accept = in_valid & in_ready, evaluated at the rising edge.
- Load: on accept, each targeted channel (in_sel, or all channels if in_bcast) loads in_data and sets out_valid[k]=1.
  - Latency is one cycle: data accepted at edge N is visible on out_data/out_valid after edge N.
- Drain: on out_valid[k] & out_ready[k] with no load to channel k, out_valid[k] clears. out_data slice k keeps its last value.
- Drain and load on the same channel in the same cycle: the new data replaces the old and out_valid[k] stays 1. This gives full throughput of one transfer per cycle per channel.
- Untargeted channels are unaffected by an accept.
- While out_valid[k] & !out_ready[k], out_data slice k and out_valid[k] stay stable (standard valid/ready stability).
- in_valid low: no state change except drains. in_data, in_sel and in_bcast are don't-care.
- Broadcast is all-or-nothing. It waits until all eight channels are free, then loads all eight in one edge. There is no partial delivery.
- Source obligations:
  - The source must not change in_data, in_sel or in_bcast while in_valid=1 and in_ready=0.
  - The block does not check this; behaviour is defined only by the values present at the accepting edge.
- acc_cnt increments by 1 per accept; a broadcast also counts as 1. It wraps from 2^CNT_W-1 to 0 with no flag.
- The block applies no ordering across channels. Order is preserved within each channel because each channel holds one entry.

Test Plan:
- Reset then unicast: in_sel=3, in_data=0xA5, in_valid=1, all out_ready=0 → next cycle out_valid=0x08, out_data[31:24]=0xA5, acc_cnt=1. A second sel=3 transfer is held with in_ready=0 while a sel=5 transfer is accepted.
- Back-pressure release: ch3 full with out_ready[3]=0; pending sel=3 data 0x3C; raise out_ready[3] → in_ready=1 in the same cycle. After the edge, out_valid[3] stays 1 and slice 3 = 0x3C (simultaneous drain and load).
- Broadcast: ch6 full and stalled; in_bcast=1, data 0x77 → in_ready=0 and no channel changes. Release ch6 → one edge loads 0x77 to all eight channels, out_valid=0xFF, acc_cnt increments by exactly 1.
- Streaming throughput: out_ready=0xFF, in_valid held high, in_sel cycling 0..7 with data 0x10..0x17 → in_ready is constantly 1, each channel shows its byte one cycle later, and 8 accepts occur in 8 cycles.
- Counter wrap (CNT_W=8): 257 accepts → acc_cnt=1.
- Async reset mid-operation: assert rst between clock edges with out_valid=0x81 → out_valid=0 and acc_cnt=0 immediately, before the next edge. After release, the first accept behaves as in the unicast scenario.
